// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared PC command encoding and strobe priority encoder
package cpu_pkg;

    localparam int DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        PC_NONE,
        PC_INC,
        PC_JMP,
        PC_CALL,
        PC_RET
    } pc_cmd_e;

    // ret > call > jmp > inc; losing strobes are discarded
    function automatic pc_cmd_e pc_cmd_sel(input logic inc, input logic jmp,
                                           input logic call, input logic ret);
        pc_cmd_e cmd;
        if (ret)       cmd = PC_RET;
        else if (call) cmd = PC_CALL;
        else if (jmp)  cmd = PC_JMP;
        else if (inc)  cmd = PC_INC;
        else           cmd = PC_NONE;
        return cmd;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO, refuses push when full and pop when empty
module ret_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = 8,
    localparam int IDX_W      = $clog2(STACK_DEPTH),
    localparam int SP_W       = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp_m1;
    logic              do_pop;
    logic              do_push;

    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;
    assign sp_m1   = sp - SP_W'(1);
    assign top_data = mem[sp_m1[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          sp <= '0;
        else if (do_pop)  sp <= sp_m1;
        else if (do_push) sp <= sp + SP_W'(1);
    end

    // Entries need no reset: sp alone defines which slots are valid
    always_ff @(posedge clk) begin
        if (do_push) mem[sp[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with call/return stack and sticky stack error flags
module pc_stack_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = 8,
    localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] pcaddr_in,
    output logic [ADDR_W-1:0] pc,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              ovf_err,
    output logic              unf_err
);

    pc_cmd_e           cmd;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] top_data;
    logic              push;
    logic              pop;

    assign cmd      = pc_cmd_sel(inc, jmp, call, ret);
    assign pc_plus1 = pc + ADDR_W'(1);
    assign push     = (cmd == PC_CALL) && !stack_full;
    assign pop      = (cmd == PC_RET) && !stack_empty;

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top_data  (top_data),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        pc_next = pc;
        case (cmd)
            PC_INC:  pc_next = pc_plus1;
            PC_JMP:  pc_next = pcaddr_in;
            PC_CALL: if (push) pc_next = pcaddr_in;
            PC_RET:  if (pop)  pc_next = top_data;
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            pc <= pc_next;
            if ((cmd == PC_CALL) && stack_full)  ovf_err <= 1'b1;
            if ((cmd == PC_RET) && stack_empty)  unf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - randomized and directed checks of pc_stack_unit against a queue-based model
module tb_pc_stack_unit;

    localparam int AW    = 8;
    localparam int DEPTH = 8;
    localparam int SPW   = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          inc, jmp, call, ret;
    logic [AW-1:0] pcaddr_in;
    logic [AW-1:0] pc;
    logic [SPW-1:0] sp;
    logic          stack_full, stack_empty, ovf_err, unf_err;

    int total = 0;
    int bad   = 0;

    int m_pc;
    int m_stack[$];
    bit m_ovf, m_unf;

    pc_stack_unit #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .inc         (inc),
        .jmp         (jmp),
        .call        (call),
        .ret         (ret),
        .pcaddr_in   (pcaddr_in),
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    32'(pc),          32'(m_pc));
        check({tag, ".sp"},    32'(sp),          32'(m_stack.size()));
        check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        check({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
        check({tag, ".unf"},   32'(unf_err),     32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit i, input bit j, input bit c, input bit r, input int a);
        if (r) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else                    m_unf = 1'b1;
        end else if (c) begin
            if (m_stack.size() == DEPTH) m_ovf = 1'b1;
            else begin
                m_stack.push_back((m_pc + 1) % 256);
                m_pc = a;
            end
        end else if (j) begin
            m_pc = a;
        end else if (i) begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic step(input string tag, input bit i, input bit j, input bit c, input bit r,
                        input int a);
        @(negedge clk);
        inc = i; jmp = j; call = c; ret = r;
        pcaddr_in = AW'(a);
        @(posedge clk);
        model_step(i, j, c, r, a);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        inc = 0; jmp = 0; call = 0; ret = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        inc = 0; jmp = 0; call = 0; ret = 0;
        pcaddr_in = '0;
        model_reset();
        #12;
        check_all("por");
        rst = 1'b0;

        // inc held three cycles
        do_reset();
        for (int k = 0; k < 3; k++) step("inc3", 1, 0, 0, 0, 0);
        check("t1.pc", 32'(pc), 32'h03);
        check("t1.sp", 32'(sp), 0);
        check("t1.empty", 32'(stack_empty), 1);

        // single call / ret
        step("jmp10", 0, 1, 0, 0, 'h10);
        step("call40", 0, 0, 1, 0, 'h40);
        check("t2.pc", 32'(pc), 32'h40);
        check("t2.sp", 32'(sp), 1);
        step("ret", 0, 0, 0, 1, 0);
        check("t2.retpc", 32'(pc), 32'h11);
        check("t2.retsp", 32'(sp), 0);

        // fill, overflow, unwind
        do_reset();
        for (int k = 0; k < 8; k++) step("nest", 0, 0, 1, 0, 'h20 + k);
        check("t3.full", 32'(stack_full), 1);
        step("call9", 0, 0, 1, 0, 'h77);
        check("t3.pc", 32'(pc), 32'h27);
        check("t3.ovf", 32'(ovf_err), 1);
        check("t3.sp", 32'(sp), 8);
        for (int k = 7; k >= 0; k--) begin
            step("unwind", 0, 0, 0, 1, 0);
            check("t3.ret", 32'(pc), (k == 0) ? 32'h01 : 32'(32'h20 + k));
        end
        check("t3.ovf_hold", 32'(ovf_err), 1);

        // underflow
        do_reset();
        step("ret_empty", 0, 0, 0, 1, 0);
        check("t4.pc", 32'(pc), 0);
        check("t4.unf", 32'(unf_err), 1);
        step("inc_after", 1, 0, 0, 0, 0);
        check("t4.pc1", 32'(pc), 1);
        check("t4.unf_hold", 32'(unf_err), 1);

        // pc wrap and wrapped return address
        do_reset();
        step("jmpff", 0, 1, 0, 0, 'hFF);
        step("incwrap", 1, 0, 0, 0, 0);
        check("t5.wrap", 32'(pc), 0);
        step("jmpff2", 0, 1, 0, 0, 'hFF);
        step("call30", 0, 0, 1, 0, 'h30);
        step("ret30", 0, 0, 0, 1, 0);
        check("t5.retwrap", 32'(pc), 0);

        // all strobes at once
        do_reset();
        step("jmp54", 0, 1, 0, 0, 'h54);
        step("call60", 0, 0, 1, 0, 'h60);
        step("all4", 1, 1, 1, 1, 'h99);
        check("t6.pc", 32'(pc), 32'h55);
        check("t6.sp", 32'(sp), 0);

        // async reset in the middle of a call
        step("jmp12", 0, 1, 0, 0, 'h12);
        step("call40b", 0, 0, 1, 0, 'h40);
        @(negedge clk);
        call = 1; pcaddr_in = 8'h50;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        @(posedge clk);
        #1;
        check_all("midrst_hold");
        @(negedge clk);
        call = 0;
        rst = 1'b0;

        // randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step("rnd",
                      $urandom_range(0, 99) < 50,
                      $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 25,
                      int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter stage sitting directly downstream of the control logic.
- Consumes the inc/jmp/call/ret strobes and pcaddr_in, and produces the instruction-memory address pc, which feeds inst back to the control logic.
- Holds an internal return-address LIFO for call/ret.
- Flags stack overflow and underflow to the rest of the core.

Parameters:
- ADDR_W, 8, width of pc, pcaddr_in and stack entries.
- STACK_DEPTH, 8, number of return-address entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- inc  input  1  advance pc by 1.
- jmp  input  1  load pc from pcaddr_in.
- call  input  1  push pc+1, load pc from pcaddr_in.
- ret  input  1  pop top of stack into pc.
- pcaddr_in  input  ADDR_W  jump/call target.
- pc  output  ADDR_W  current program counter (registered).
- sp  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_full  output  1  sp == STACK_DEPTH.
- stack_empty  output  1  sp == 0.
- ovf_err  output  1  sticky: call attempted while full.
- unf_err  output  1  sticky: ret attempted while empty.

Behaviour:
- Reset (async, active-high): pc=0, sp=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0. Stack contents are don't-care.
- Clock/reset: single clock domain. All state updates on the rising clk edge. rst asserted mid-operation aborts any push/pop immediately.
- Strobe sampling: strobes are level-sampled every cycle. A strobe held N cycles acts N times; the control logic is responsible for one-cycle pulses.
- Latency: one cycle. pc reflects a command on the edge that samples it, and is visible the following cycle.
- Priority when several strobes are high in the same cycle: ret > call > jmp > inc. Only the winner executes; the others are discarded.
- Command decode (registered 2-state-per-command FSM is not needed; pure next-state select):
  - NONE: pc holds.
  - INC: pc <= pc+1, modulo 2^ADDR_W (0xFF -> 0x00 at default width).
  - JMP: pc <= pcaddr_in. Stack is untouched.
  - CALL, not full: stack[sp] <= pc+1 (wrapped); sp <= sp+1; pc <= pcaddr_in.
  - CALL, full: no push, pc holds, ovf_err <= 1.
  - RET, not empty: pc <= stack[sp-1]; sp <= sp-1.
  - RET, empty: pc holds, sp stays 0, unf_err <= 1.
- Error flags: ovf_err and unf_err are cleared only by rst. Commands keep executing normally while an error flag is set.
- Status flags: stack_full and stack_empty are combinational decodes of registered sp, so they are glitch-free relative to clk.
- Simultaneous call+ret: ret wins per priority. No push and pop in the same cycle.
- Boundary cases:
  - sp ranges 0..STACK_DEPTH inclusive; it never wraps.
  - The return address pushed at pc=0xFF is 0x00.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W default constant.
  - pc_cmd_e enum {PC_NONE, PC_INC, PC_JMP, PC_CALL, PC_RET}.
  - Priority-encode function from the four strobes to pc_cmd_e.
- Sub-module ret_stack: synchronous-write LIFO with inputs clk, rst, push, pop, push_data; outputs top_data, sp, full, empty.
  - It refuses a push when full and a pop when empty.
- pc_stack_unit itself holds the pc register, the command select and the sticky error flags.

Test Plan:
- Reset then inc held 3 cycles -> pc = 0x03; sp = 0; stack_empty = 1.
- pc = 0x10, call with pcaddr_in = 0x40 -> next cycle pc = 0x40, sp = 1. Then ret -> pc = 0x11, sp = 0.
- Nested calls: 8 calls to 0x20..0x27 from successive pcs -> stack_full = 1. A 9th call -> pc holds, ovf_err = 1, sp = 8. Then 8 rets return the pushed addresses in reverse order.
- Ret at reset state -> pc stays 0x00, unf_err = 1, sp = 0. A subsequent inc still works (pc = 0x01); unf_err stays 1 until rst.
- pc = 0xFF: inc -> pc = 0x00. From pc = 0xFF, call to 0x30 then ret -> pc = 0x00.
- Priority and reset:
  - inc+jmp+call+ret together with sp = 1 (top = 0x55) -> pc = 0x55, sp = 0, no push.
  - rst asserted mid-cycle during a call -> all outputs return to reset values asynchronously.
